// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer port arbiter.
//   swap_state_t : double-buffer swap FSM states
//   rgb565_t     : packed RGB565 pixel
//   ADDR_W_DEF / PIX_W_DEF : default per-bank address width and pixel width
package fb_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 19;  // 640x480 = 307200 pixels per bank
  localparam int unsigned PIX_W_DEF  = 16;

  typedef enum logic [1:0] {
    WRITE   = 2'd0,
    WAIT_VB = 2'd1,
    SWAP    = 2'd2
  } swap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the arbiter and its environment (VGA timing, writer, SRAM).
//   slave  : arbiter view (takes requests, drives grants, pixels and SRAM controls)
//   master : environment view (drives requests and SRAM read data)
interface fb_port_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
) ();

  // Display side
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              vblank;
  logic [PIX_W-1:0]  disp_pixel;
  // Writer side
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_gnt;
  logic              wr_frame_done;
  logic              wr_buf_ready;
  logic              front_buf;
  logic              wr_starve;
  // SRAM side
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  disp_req, disp_addr, vblank, wr_req, wr_addr, wr_data, wr_frame_done, mem_rdata,
    output disp_pixel, wr_gnt, wr_buf_ready, front_buf, wr_starve, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, vblank, wr_req, wr_addr, wr_data, wr_frame_done, mem_rdata,
    input  disp_pixel, wr_gnt, wr_buf_ready, front_buf, wr_starve, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_swap_fsm.sv
// Double-buffer swap controller.
//   pclk, reset_n        : clock, asynchronous active-low reset
//   i_frame_done         : writer finished filling the back bank (one-cycle pulse)
//   i_vblank             : vertical blanking level from the timing generator
//   o_write_enable_ok    : writes may be granted (state WRITE)
//   o_front_buf          : bank currently displayed
//   o_buf_ready          : one-cycle pulse during the swap cycle
module fb_swap_fsm
  import fb_arb_pkg::*;
(
  input  logic pclk,
  input  logic reset_n,
  input  logic i_frame_done,
  input  logic i_vblank,
  output logic o_write_enable_ok,
  output logic o_front_buf,
  output logic o_buf_ready
);

  swap_state_t r_state, w_state_d;
  logic        r_vblank;
  logic        r_front_buf;
  logic        w_vb_rise;

  assign w_vb_rise = i_vblank & ~r_vblank;

  // State register, vblank history and displayed bank
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= WRITE;
      r_vblank    <= 1'b0;
      r_front_buf <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_vblank <= i_vblank;
      if (r_state == SWAP) begin
        r_front_buf <= ~r_front_buf;
      end
    end
  end

  // Next state; a frame_done seen while already in WAIT_VB is deliberately ignored
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      WRITE:   if (i_frame_done) w_state_d = WAIT_VB;
      WAIT_VB: if (w_vb_rise)    w_state_d = SWAP;
      SWAP:                      w_state_d = WRITE;
      default:                   w_state_d = WRITE;
    endcase
  end

  // Outputs
  always_comb begin
    o_write_enable_ok = (r_state == WRITE);
    o_buf_ready       = (r_state == SWAP);
    o_front_buf       = r_front_buf;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port SRAM between the display
// reader (absolute priority, front bank) and the result writer (back bank),
// with bank swap deferred to the start of vertical blanking.
//   pclk, reset_n : pixel clock, asynchronous active-low reset
//   bus (slave)   : display request/pixel, writer handshake, SRAM controls
// Parameters: ADDR_W per-bank address width, PIX_W pixel width,
//             STARVE_LIMIT denied write cycles before wr_starve sets.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned PIX_W        = PIX_W_DEF,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic               pclk,
  input  logic               reset_n,
  fb_port_arbiter_if.slave   bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic              w_write_ok;
  logic              w_front_buf;
  logic              w_buf_ready;
  logic              w_gnt;
  logic [ADDR_W:0]   w_mem_addr;
  logic [PIX_W-1:0]  w_mem_wdata;
  logic [CntW-1:0]   w_cnt_d;

  logic [ADDR_W:0]   r_mem_addr;
  logic [PIX_W-1:0]  r_mem_wdata;
  logic              r_rd_pend;
  logic [PIX_W-1:0]  r_disp_pixel;
  logic [CntW-1:0]   r_cnt;
  logic              r_starve;

  fb_swap_fsm u_swap_fsm (
    .pclk              (pclk),
    .reset_n           (reset_n),
    .i_frame_done      (bus.wr_frame_done),
    .i_vblank          (bus.vblank),
    .o_write_enable_ok (w_write_ok),
    .o_front_buf       (w_front_buf),
    .o_buf_ready       (w_buf_ready)
  );

  assign w_gnt = ~bus.disp_req & bus.wr_req & w_write_ok;

  // Same-cycle arbitration; address/data hold their last driven value when idle
  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    if (bus.disp_req) begin
      w_mem_addr = {w_front_buf, bus.disp_addr};
    end else if (w_gnt) begin
      w_mem_addr  = {~w_front_buf, bus.wr_addr};
      w_mem_wdata = bus.wr_data;
    end
  end

  // Starvation counter: counts denied cycles only while writes are allowed
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_gnt) begin
      w_cnt_d = '0;
    end else if (bus.wr_req && w_write_ok && (r_cnt != CntMax)) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rd_pend    <= 1'b0;
      r_disp_pixel <= '0;
      r_cnt        <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rd_pend   <= bus.disp_req;
      // SRAM data for a read issued last cycle is valid now
      if (r_rd_pend) begin
        r_disp_pixel <= bus.mem_rdata;
      end
      r_cnt <= w_cnt_d;
      if (w_cnt_d == CntMax) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.mem_we       = w_gnt;
  assign bus.wr_gnt       = w_gnt;
  assign bus.disp_pixel   = r_disp_pixel;
  assign bus.front_buf    = w_front_buf;
  assign bus.wr_buf_ready = w_buf_ready;
  assign bus.wr_starve    = r_starve;

endmodule
